// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: timed chip-select / strobe sequencer for an RTC with a
// multiplexed address/data bus. Each command runs an address phase then a data
// phase, each split into setup, strobe and hold, followed by a one-cycle DONE.
// Optional build macro RTC_SEQ_QUEUE_EN adds a one-entry command buffer so a
// command issued while busy starts straight after DONE.
module rtc_bus_sequencer #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int T_SU = 10,
  parameter int T_PW = 20,
  parameter int T_HD = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cmd_write,
  input  logic [DW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic [DW-1:0] bus_in,
  output logic          cs_n,
  output logic          wr_n,
  output logic          rd_n,
  output logic          ad,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          cmd_ready
);

  typedef enum logic [2:0] {
    IDLE, A_SU, A_STB, A_HD, D_SU, D_STB, D_HD, DONE
  } state_t;

  localparam logic [CW-1:0] SU_LAST = CW'(T_SU - 1);
  localparam logic [CW-1:0] PW_LAST = CW'(T_PW - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(T_HD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          cmd_write_q, cmd_write_d;
  logic [DW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0] phase_last;
  logic          phase_end;

`ifdef RTC_SEQ_QUEUE_EN
  logic          buf_full_q, buf_full_d;
  logic          buf_write_q, buf_write_d;
  logic [DW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_data_q, buf_data_d;

  // The entry is released during DONE, so a new command may land in it there.
  assign cmd_ready = !buf_full_q || (state_q == DONE);
`else
  assign cmd_ready = (state_q == IDLE);
`endif

  assign rd_data = rd_data_q;

  // Select the terminal timer value for the current phase.
  always_comb begin
    phase_last = '0;
    unique case (state_q)
      A_SU, D_SU:   phase_last = SU_LAST;
      A_STB, D_STB: phase_last = PW_LAST;
      A_HD, D_HD:   phase_last = HD_LAST;
      default:      phase_last = '0;
    endcase
  end

  assign phase_end = (timer_q == phase_last);

  // Next-state, command latch, read capture and phase timer reload.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + CW'(1);
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    rd_data_d   = rd_data_q;
`ifdef RTC_SEQ_QUEUE_EN
    buf_full_d  = buf_full_q;
    buf_write_d = buf_write_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_write_d = cmd_write;
          cmd_addr_d  = cmd_addr;
          cmd_data_d  = cmd_data;
          state_d     = A_SU;
        end
      end
      A_SU:  if (phase_end) state_d = A_STB;
      A_STB: if (phase_end) state_d = A_HD;
      A_HD:  if (phase_end) state_d = D_SU;
      D_SU:  if (phase_end) state_d = D_STB;
      D_STB: begin
        if (phase_end) begin
          state_d = D_HD;
          if (!cmd_write_q) rd_data_d = bus_in;
        end
      end
      D_HD:  if (phase_end) state_d = DONE;
      DONE: begin
        state_d = IDLE;
`ifdef RTC_SEQ_QUEUE_EN
        if (buf_full_q) begin
          cmd_write_d = buf_write_q;
          cmd_addr_d  = buf_addr_q;
          cmd_data_d  = buf_data_q;
          buf_full_d  = 1'b0;
          state_d     = A_SU;
          if (start) begin
            buf_write_d = cmd_write;
            buf_addr_d  = cmd_addr;
            buf_data_d  = cmd_data;
            buf_full_d  = 1'b1;
          end
        end else if (start) begin
          cmd_write_d = cmd_write;
          cmd_addr_d  = cmd_addr;
          cmd_data_d  = cmd_data;
          state_d     = A_SU;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef RTC_SEQ_QUEUE_EN
    if (start && !buf_full_q && state_q != IDLE && state_q != DONE) begin
      buf_write_d = cmd_write;
      buf_addr_d  = cmd_addr;
      buf_data_d  = cmd_data;
      buf_full_d  = 1'b1;
    end
`endif
    if (state_d != state_q || state_q == IDLE) timer_d = '0;
  end

  // Bus pin values decoded from the current phase and latched command.
  always_comb begin
    cs_n     = 1'b1;
    wr_n     = 1'b1;
    rd_n     = 1'b1;
    ad       = 1'b1;
    bus_out  = '0;
    bus_oe   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    rd_valid = 1'b0;
    unique case (state_q)
      IDLE: busy = 1'b0;
      A_SU, A_HD: begin
        ad      = 1'b0;
        bus_out = cmd_addr_q;
        bus_oe  = 1'b1;
      end
      A_STB: begin
        ad      = 1'b0;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        bus_out = cmd_addr_q;
        bus_oe  = 1'b1;
      end
      D_SU, D_HD: begin
        if (cmd_write_q) begin
          bus_out = cmd_data_q;
          bus_oe  = 1'b1;
        end
      end
      D_STB: begin
        cs_n = 1'b0;
        if (cmd_write_q) begin
          wr_n    = 1'b0;
          bus_out = cmd_data_q;
          bus_oe  = 1'b1;
        end else begin
          rd_n = 1'b0;
        end
      end
      DONE: begin
        done     = 1'b1;
        rd_valid = !cmd_write_q;
      end
      default: busy = 1'b0;
    endcase
  end

  // State, timer, command and capture registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      rd_data_q   <= '0;
`ifdef RTC_SEQ_QUEUE_EN
      buf_full_q  <= 1'b0;
      buf_write_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      rd_data_q   <= rd_data_d;
`ifdef RTC_SEQ_QUEUE_EN
      buf_full_q  <= buf_full_d;
      buf_write_q <= buf_write_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench for rtc_bus_sequencer: a default-timing instance and a
// single-cycle-phase instance, driven from a vector table with a read-data
// scoreboard, plus hand-written reset-abort and held-start sequences.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       use_fast;
  logic       cmd_write;
  logic [7:0] cmd_addr, cmd_data, bus_in;

  logic       start_main, start_fast;
  logic       m_cs_n, m_wr_n, m_rd_n, m_ad, m_bus_oe, m_rd_valid, m_busy, m_done, m_cmd_ready;
  logic [7:0] m_bus_out, m_rd_data;
  logic       f_cs_n, f_wr_n, f_rd_n, f_ad, f_bus_oe, f_rd_valid, f_busy, f_done, f_cmd_ready;
  logic [7:0] f_bus_out, f_rd_data;
  logic       o_cs_n, o_wr_n, o_rd_n, o_ad, o_bus_oe, o_rd_valid, o_busy, o_done, o_cmd_ready;
  logic [7:0] o_bus_out, o_rd_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       fast;
    logic       write;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] bus_val;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  assign start_main = start && !use_fast;
  assign start_fast = start && use_fast;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .start(start_main), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bus_in(bus_in),
    .cs_n(m_cs_n), .wr_n(m_wr_n), .rd_n(m_rd_n), .ad(m_ad),
    .bus_out(m_bus_out), .bus_oe(m_bus_oe), .rd_data(m_rd_data),
    .rd_valid(m_rd_valid), .busy(m_busy), .done(m_done), .cmd_ready(m_cmd_ready)
  );

  rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_HD(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start_fast), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bus_in(bus_in),
    .cs_n(f_cs_n), .wr_n(f_wr_n), .rd_n(f_rd_n), .ad(f_ad),
    .bus_out(f_bus_out), .bus_oe(f_bus_oe), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .busy(f_busy), .done(f_done), .cmd_ready(f_cmd_ready)
  );

  assign o_cs_n      = use_fast ? f_cs_n      : m_cs_n;
  assign o_wr_n      = use_fast ? f_wr_n      : m_wr_n;
  assign o_rd_n      = use_fast ? f_rd_n      : m_rd_n;
  assign o_ad        = use_fast ? f_ad        : m_ad;
  assign o_bus_out   = use_fast ? f_bus_out   : m_bus_out;
  assign o_bus_oe    = use_fast ? f_bus_oe    : m_bus_oe;
  assign o_rd_data   = use_fast ? f_rd_data   : m_rd_data;
  assign o_rd_valid  = use_fast ? f_rd_valid  : m_rd_valid;
  assign o_busy      = use_fast ? f_busy      : m_busy;
  assign o_done      = use_fast ? f_done      : m_done;
  assign o_cmd_ready = use_fast ? f_cmd_ready : m_cmd_ready;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int su, pw, hd, ph;
    int ad_low, cs_low, wr_a, wr_d, rd_low, busy_cnt, a_oe, d_oe, bus_err, overlap, done_at;
    exp_t e, got;
    bit got_done;
    su = v.fast ? 1 : 10;
    pw = v.fast ? 1 : 20;
    hd = v.fast ? 1 : 10;
    ph = su + pw + hd;
    @(negedge clk);
    use_fast  = v.fast;
    start     = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    bus_in    = ~v.bus_val;
    e.valid   = v.exp_valid;
    e.data    = v.exp_data;
    sb.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = ~v.addr;
    cmd_data  = ~v.data;
    ad_low = 0; cs_low = 0; wr_a = 0; wr_d = 0; rd_low = 0; busy_cnt = 0;
    a_oe = 0; d_oe = 0; bus_err = 0; overlap = 0; done_at = -1; got_done = 0;
    for (int n = 0; n < 300 && !got_done; n++) begin
      if (n > 0) @(negedge clk);
      if (o_busy) busy_cnt++;
      if (!o_ad) ad_low++;
      if (!o_cs_n) cs_low++;
      if (!o_wr_n && !o_ad) wr_a++;
      if (!o_wr_n && o_ad) wr_d++;
      if (!o_rd_n) rd_low++;
      if (!o_wr_n && !o_rd_n) overlap++;
      if (o_bus_oe && !o_ad) begin
        a_oe++;
        if (o_bus_out !== v.addr) bus_err++;
      end
      if (o_bus_oe && o_ad) begin
        d_oe++;
        if (!v.write || o_bus_out !== v.data) bus_err++;
      end
      bus_in = (!o_rd_n) ? v.bus_val : ~v.bus_val;
      if (o_done) begin
        got_done = 1;
        done_at  = n;
        if (sb.size() == 0) begin
          checkOutput("scoreboard_empty", 0, 1);
        end else begin
          got = sb.pop_front();
          checkOutput("rd_valid", o_rd_valid, got.valid);
          if (got.valid) checkOutput("rd_data", o_rd_data, got.data);
        end
      end
    end
    if (!got_done) checkOutput("done_timeout", 0, 1);
    checkOutput("done_offset", done_at, 2 * ph);
    checkOutput("busy_width", busy_cnt, 2 * ph + 1);
    checkOutput("ad_low", ad_low, ph);
    checkOutput("cs_low", cs_low, 2 * pw);
    checkOutput("wr_low_addr", wr_a, pw);
    checkOutput("wr_low_data", wr_d, v.write ? pw : 0);
    checkOutput("rd_low", rd_low, v.write ? 0 : pw);
    checkOutput("strobe_overlap", overlap, 0);
    checkOutput("addr_oe_cycles", a_oe, ph);
    checkOutput("data_oe_cycles", d_oe, v.write ? ph : 0);
    checkOutput("bus_value_err", bus_err, 0);
    @(negedge clk);
    checkOutput("idle_busy", o_busy, 0);
    checkOutput("idle_ready", o_cmd_ready, 1);
    checkOutput("idle_oe", o_bus_oe, 0);
  endtask

  // Global watchdog so a stuck DUT still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, cnt, a_err, d_err, done_at;

    vecs[0] = '{fast: 1'b0, write: 1'b1, addr: 8'h21, data: 8'h5A, bus_val: 8'h00, exp_valid: 1'b0, exp_data: 8'h00};
    vecs[1] = '{fast: 1'b0, write: 1'b0, addr: 8'h22, data: 8'h00, bus_val: 8'hC3, exp_valid: 1'b1, exp_data: 8'hC3};
    vecs[2] = '{fast: 1'b0, write: 1'b1, addr: 8'hFF, data: 8'h00, bus_val: 8'h66, exp_valid: 1'b0, exp_data: 8'h00};
    vecs[3] = '{fast: 1'b0, write: 1'b0, addr: 8'h00, data: 8'hFF, bus_val: 8'hFF, exp_valid: 1'b1, exp_data: 8'hFF};
    vecs[4] = '{fast: 1'b1, write: 1'b1, addr: 8'h21, data: 8'h5A, bus_val: 8'h11, exp_valid: 1'b0, exp_data: 8'h00};
    vecs[5] = '{fast: 1'b1, write: 1'b0, addr: 8'h80, data: 8'h00, bus_val: 8'h3C, exp_valid: 1'b1, exp_data: 8'h3C};

    reset = 1'b1; start = 1'b0; use_fast = 1'b0; cmd_write = 1'b0;
    cmd_addr = 8'h00; cmd_data = 8'h00; bus_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_strobes", {o_cs_n, o_wr_n, o_rd_n}, 3'b111);
    checkOutput("reset_ad", o_ad, 1);
    checkOutput("reset_oe", o_bus_oe, 0);
    checkOutput("reset_bus_out", o_bus_out, 0);
    checkOutput("reset_rd_data", o_rd_data, 0);
    checkOutput("reset_pulses", {o_rd_valid, o_done}, 2'b00);
    checkOutput("reset_ready", o_cmd_ready, 1);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset pulsed in the middle of the address strobe of a write.
    @(negedge clk);
    use_fast = 1'b0; start = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_data = 8'h99;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (o_cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reached_strobe", o_cs_n, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_strobes", {o_cs_n, o_wr_n, o_rd_n}, 3'b111);
    checkOutput("abort_oe", o_bus_oe, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_ready", o_cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done || o_busy) cnt++;
    end
    checkOutput("abort_no_done", cnt, 0);
    applyStimulus('{fast: 1'b0, write: 1'b1, addr: 8'h21, data: 8'h5A, bus_val: 8'h00, exp_valid: 1'b0, exp_data: 8'h00});

    // Start held high through a write while command inputs change.
    @(negedge clk);
    use_fast = 1'b0; start = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_data = 8'h44;
    @(negedge clk);
    cmd_addr = 8'h77; cmd_data = 8'h88; cmd_write = 1'b0;
    a_err = 0; d_err = 0; done_at = -1;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      if (!o_ad && o_bus_oe && o_bus_out !== 8'h33) a_err++;
      if (o_ad && o_bus_oe && o_bus_out !== 8'h44) d_err++;
      if (o_done) begin
        done_at = i;
        break;
      end
    end
    checkOutput("held_addr", a_err, 0);
    checkOutput("held_data", d_err, 0);
    checkOutput("held_done_offset", done_at, 80);
    @(negedge clk);
`ifdef RTC_SEQ_QUEUE_EN
    checkOutput("held_busy_continuous", o_busy, 1);
    start = 1'b0;
    n = 0;
    while (o_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_drained", o_busy, 0);
`else
    checkOutput("held_busy_after_done", o_busy, 0);
    checkOutput("held_ready_after_done", o_cmd_ready, 1);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done || o_busy) cnt++;
    end
    checkOutput("held_no_extra_cycle", cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameter DW, 8, width of the multiplexed address/data bus.
REQ-002 Parameter CW, 8, width of the phase timer; all T_* values are limited to 1..2^CW-1.
REQ-003 Parameter T_SU, 10, setup phase length in clk cycles.
REQ-004 Parameter T_PW, 20, strobe (cs_n/wr_n/rd_n low) length in clk cycles.
REQ-005 Parameter T_HD, 10, hold phase length in clk cycles.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  command request, accepted when start=1 and cmd_ready=1.
REQ-009 cmd_write  in  1  1=write cycle, 0=read cycle.
REQ-010 cmd_addr  in  DW  device register address.
REQ-011 cmd_data  in  DW  write data, ignored for reads.
REQ-012 bus_in  in  DW  bus value from the pad, sampled on reads.
REQ-013 cs_n, wr_n, rd_n  out  1 each  active-low chip select, write strobe and read strobe.
REQ-014 ad  out  1  0=address phase, 1=data phase.
REQ-015 bus_out  out  DW  driven bus value; bus_oe  out  1  pad output enable.
REQ-016 rd_data  out  DW  captured read value; rd_valid  out  1  one-cycle pulse marking rd_data new.
REQ-017 busy  out  1  cycle in progress; done  out  1  one-cycle end-of-cycle pulse; cmd_ready  out  1  command can be accepted.

Function
REQ-018 States: IDLE, A_SU, A_STB, A_HD, D_SU, D_STB, D_HD, DONE; A_SU/D_SU last T_SU cycles, A_STB/D_STB T_PW, A_HD/D_HD T_HD, DONE 1.
REQ-019 Phase timer reloads on every state entry; a state exits when its timer reaches its length-1.
REQ-020 IDLE: all strobes 1, ad=1, bus_oe=0, busy=0; accepted command latched (write, addr, data) and next state A_SU.
REQ-021 A_SU: ad=0, cs_n=1, bus_out=addr, bus_oe=1; A_STB: cs_n=0, wr_n=0; A_HD: cs_n=1, wr_n=1, addr still driven.
REQ-022 D_SU: ad=1, cs_n=1; write drives bus_out=data, bus_oe=1; read bus_oe=0.
REQ-023 D_STB: cs_n=0; write wr_n=0, read rd_n=0; read captures bus_in into rd_data on the last D_STB cycle.
REQ-024 D_HD: strobes 1, write keeps data driven, read keeps bus_oe=0.
REQ-025 DONE: done=1, rd_valid=1 only for reads, bus_oe=0, then IDLE.
REQ-026 busy=1 in every state except IDLE; busy pulse width = 2*(T_SU+T_PW+T_HD)+1 cycles.
REQ-027 rd_n never 0 on a write cycle, wr_n never 0 in D_STB of a read, wr_n and rd_n never 0 together.
REQ-028 cmd_ready=1 only in IDLE; start while busy is ignored, with no effect on the cycle in progress.
REQ-029 Latched command is stable for the whole cycle; input changes after acceptance have no effect.

Reset
REQ-030 reset asserted at any time forces IDLE immediately: cs_n=wr_n=rd_n=1, ad=1, bus_oe=0, bus_out=0, rd_data=0, rd_valid=done=busy=0, cmd_ready=1.
REQ-031 Reset mid-cycle aborts the cycle without a done pulse; the first command after release starts a complete cycle from A_SU.

Configuration
REQ-032 Macro RTC_SEQ_QUEUE_EN defined: a one-entry command buffer; cmd_ready=!buffer_full; start while busy fills the buffer.
REQ-033 With RTC_SEQ_QUEUE_EN: DONE goes directly to A_SU when the buffer is full (no IDLE cycle), freeing it; start in that same DONE cycle is accepted into the freed entry.
REQ-034 Without RTC_SEQ_QUEUE_EN: no buffer logic, behaviour exactly as in REQ-028.

Verification
REQ-035 Defaults, write addr=0x21 data=0x5A -> ad low 40 cycles, wr_n low 20 cycles twice, bus=0x21 then 0x5A, done exactly 80 cycles after busy rise.
REQ-036 Read addr=0x22, bus_in=0xC3 during D_STB -> rd_n low 20 cycles, bus_oe=0 in D phase, rd_data=0xC3 with rd_valid and done in same cycle.
REQ-037 T_SU=T_PW=T_HD=1 write -> busy 7 cycles, every phase exactly 1 cycle.
REQ-038 reset pulsed during A_STB of a write -> strobes return to 1 and bus_oe=0 asynchronously, no done; next command completes normally.
REQ-039 start held during a write -> ignored without the macro; with RTC_SEQ_QUEUE_EN second cycle begins the cycle after DONE, busy continuous.
REQ-040 Read followed by write -> rd_n never low in the write, wr_n never low in the read D_STB.
